// File: rtl/rupt_priority_scheduler.sv
// Interrupt (rupt) priority scheduler.
// Latches per-source request strobes into PEND and arbitrates them by fixed
// priority, with bit 0 the highest. A single 4-state FSM raises RUPTOR_n toward
// the sequencer on an end-of-memory-cycle strobe (T12). It then tracks the
// acknowledge (KRPT) and the end of service (RESUME).
module rupt_priority_scheduler #(
    parameter int NRUPT = 10,
    parameter int VW    = 4
) (
    input  logic             CLOCK,
    input  logic             SIM_RST,
    input  logic [NRUPT-1:0] RUPT_REQ,
    input  logic             INHINT,
    input  logic             OVNHRP,
    input  logic             MNHRPT,
    input  logic             T12,
    input  logic             KRPT,
    input  logic             RESUME,
    output logic             RUPTOR_n,
    output logic [VW-1:0]    RPTADR,
    output logic [NRUPT-1:0] PEND,
    output logic             IIP
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        REQ     = 2'd2,
        SERVICE = 2'd3
    } state_t;

    state_t           state;
    logic             block;
    logic [NRUPT-1:0] clr_mask;

    // Index + 1 of the lowest set bit, or 0 when no bit is set.
    function automatic logic [VW-1:0] first_index(input logic [NRUPT-1:0] bits);
        logic [VW-1:0] idx;
        idx = '0;
        for (int i = NRUPT - 1; i >= 0; i--) begin
            if (bits[i]) idx = VW'(i + 1);
        end
        return idx;
    endfunction

    // Any inhibit source, including a rupt already in service, blocks arming.
    always_comb begin
        block = INHINT | OVNHRP | MNHRPT | IIP;
    end

    // The acknowledged grant is the only pending bit that may ever be cleared.
    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < NRUPT; i++) begin
            if (state == REQ && KRPT && RPTADR == VW'(i + 1)) clr_mask[i] = 1'b1;
        end
    end

    // Pending latch and scheduler FSM. All outputs are registered here.
    always_ff @(posedge CLOCK or posedge SIM_RST) begin
        if (SIM_RST) begin
            state    <= IDLE;
            PEND     <= '0;
            RPTADR   <= '0;
            IIP      <= 1'b0;
            RUPTOR_n <= 1'b1;
        end else begin
            // A new strobe wins over a same-edge clear of the same bit.
            PEND <= (PEND & ~clr_mask) | RUPT_REQ;
            case (state)
                IDLE: begin
                    if (PEND != '0 && !block) state <= ARMED;
                end
                ARMED: begin
                    // T12 is only honoured after a full cycle in ARMED.
                    if (block || PEND == '0) begin
                        state <= IDLE;
                    end else if (T12) begin
                        state    <= REQ;
                        RUPTOR_n <= 1'b0;
                        RPTADR   <= first_index(PEND);
                    end
                end
                REQ: begin
                    // The acknowledge takes precedence over a same-edge inhibit.
                    if (KRPT) begin
                        state    <= SERVICE;
                        RUPTOR_n <= 1'b1;
                        IIP      <= 1'b1;
                    end else if (INHINT | OVNHRP | MNHRPT) begin
                        state    <= IDLE;
                        RUPTOR_n <= 1'b1;
                        RPTADR   <= '0;
                    end
                end
                SERVICE: begin
                    if (RESUME) begin
                        state  <= IDLE;
                        IIP    <= 1'b0;
                        RPTADR <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rupt_priority_scheduler.sv
// Directed testbench for rupt_priority_scheduler with hand-computed expectations.
module tb_rupt_priority_scheduler;

    localparam int NRUPT = 10;
    localparam int VW    = 4;

    logic             CLOCK;
    logic             SIM_RST;
    logic [NRUPT-1:0] RUPT_REQ;
    logic             INHINT;
    logic             OVNHRP;
    logic             MNHRPT;
    logic             T12;
    logic             KRPT;
    logic             RESUME;
    logic             RUPTOR_n;
    logic [VW-1:0]    RPTADR;
    logic [NRUPT-1:0] PEND;
    logic             IIP;

    int total = 0;
    int bad   = 0;

    rupt_priority_scheduler #(.NRUPT(NRUPT), .VW(VW)) dut (
        .CLOCK    (CLOCK),
        .SIM_RST  (SIM_RST),
        .RUPT_REQ (RUPT_REQ),
        .INHINT   (INHINT),
        .OVNHRP   (OVNHRP),
        .MNHRPT   (MNHRPT),
        .T12      (T12),
        .KRPT     (KRPT),
        .RESUME   (RESUME),
        .RUPTOR_n (RUPTOR_n),
        .RPTADR   (RPTADR),
        .PEND     (PEND),
        .IIP      (IIP)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int rn, input int adr, input int pend, input int iip);
        chk({tag, "_ruptor_n"}, 32'(RUPTOR_n), 32'(rn));
        chk({tag, "_rptadr"},   32'(RPTADR),   32'(adr));
        chk({tag, "_pend"},     32'(PEND),     32'(pend));
        chk({tag, "_iip"},      32'(IIP),      32'(iip));
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic clear_inputs();
        RUPT_REQ = '0;
        T12      = 1'b0;
        KRPT     = 1'b0;
        RESUME   = 1'b0;
        INHINT   = 1'b0;
        OVNHRP   = 1'b0;
        MNHRPT   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        SIM_RST = 1'b1;
        clear_inputs();
        #12;
        chk_out("rst", 1, 0, 'h000, 0);
        RUPT_REQ = '1; T12 = 1'b1; KRPT = 1'b1; RESUME = 1'b1;
        step();
        chk_out("rst_ign", 1, 0, 'h000, 0);
        #2;
        SIM_RST = 1'b0;
        clear_inputs();

        // basic grant
        RUPT_REQ = 10'h008; step(); RUPT_REQ = '0;
        chk_out("b_pend", 1, 0, 'h008, 0);
        step();
        chk_out("b_arm", 1, 0, 'h008, 0);
        T12 = 1'b1; step(); T12 = 1'b0;
        chk_out("b_req", 0, 4, 'h008, 0);
        step();
        chk_out("b_hold", 0, 4, 'h008, 0);
        KRPT = 1'b1; step(); KRPT = 1'b0;
        chk_out("b_krpt", 1, 4, 'h000, 1);
        RESUME = 1'b1; step(); RESUME = 1'b0;
        chk_out("b_resume", 1, 0, 'h000, 0);

        // priority, plus T12 on the ARMED-entry edge being ignored
        RUPT_REQ = 10'h210; step(); RUPT_REQ = '0;
        chk_out("p_pend", 1, 0, 'h210, 0);
        T12 = 1'b1; step();
        chk_out("p_t12arm", 1, 0, 'h210, 0);
        step(); T12 = 1'b0;
        chk_out("p_req1", 0, 5, 'h210, 0);
        KRPT = 1'b1; step(); KRPT = 1'b0;
        chk_out("p_k1", 1, 5, 'h200, 1);
        RESUME = 1'b1; step(); RESUME = 1'b0;
        chk_out("p_r1", 1, 0, 'h200, 0);
        step();
        T12 = 1'b1; step(); T12 = 1'b0;
        chk_out("p_req2", 0, 10, 'h200, 0);
        KRPT = 1'b1; step(); KRPT = 1'b0;
        chk_out("p_k2", 1, 10, 'h000, 1);
        RESUME = 1'b1; step(); RESUME = 1'b0;
        chk_out("p_r2", 1, 0, 'h000, 0);
        KRPT = 1'b1; RESUME = 1'b1; step(); KRPT = 1'b0; RESUME = 1'b0;
        chk_out("p_stray", 1, 0, 'h000, 0);

        // inhibit
        INHINT = 1'b1;
        RUPT_REQ = 10'h001; step(); RUPT_REQ = '0;
        chk_out("i_pend", 1, 0, 'h001, 0);
        for (int k = 0; k < 3; k++) begin
            T12 = 1'b1; step(); T12 = 1'b0;
            chk_out("i_t12", 1, 0, 'h001, 0);
            step();
        end
        INHINT = 1'b0; step();
        T12 = 1'b1; step(); T12 = 1'b0;
        chk_out("i_req", 0, 1, 'h001, 0);
        KRPT = 1'b1; step(); KRPT = 1'b0;
        chk_out("i_k", 1, 1, 'h000, 1);
        RESUME = 1'b1; step(); RESUME = 1'b0;
        chk_out("i_r", 1, 0, 'h000, 0);

        // withdraw, then KRPT winning over a same-edge inhibit
        RUPT_REQ = 10'h004; step(); RUPT_REQ = '0;
        step();
        T12 = 1'b1; step(); T12 = 1'b0;
        chk_out("w_req", 0, 3, 'h004, 0);
        OVNHRP = 1'b1; step();
        chk_out("w_wd", 1, 0, 'h004, 0);
        T12 = 1'b1; step(); T12 = 1'b0;
        chk_out("w_blk", 1, 0, 'h004, 0);
        OVNHRP = 1'b0; step();
        T12 = 1'b1; step(); T12 = 1'b0;
        chk_out("w_rereq", 0, 3, 'h004, 0);
        KRPT = 1'b1; INHINT = 1'b1; step(); KRPT = 1'b0; INHINT = 1'b0;
        chk_out("w_kwin", 1, 3, 'h000, 1);
        RESUME = 1'b1; step(); RESUME = 1'b0;
        chk_out("w_r", 1, 0, 'h000, 0);

        // simultaneous KRPT and re-request of the granted bit
        RUPT_REQ = 10'h020; step(); RUPT_REQ = '0;
        step();
        T12 = 1'b1; step(); T12 = 1'b0;
        chk_out("s_req", 0, 6, 'h020, 0);
        KRPT = 1'b1; RUPT_REQ = 10'h020; step(); KRPT = 1'b0; RUPT_REQ = '0;
        chk_out("s_k", 1, 6, 'h020, 1);
        RESUME = 1'b1; step(); RESUME = 1'b0;
        chk_out("s_r", 1, 0, 'h020, 0);
        step();
        T12 = 1'b1; step(); T12 = 1'b0;
        chk_out("s_regrant", 0, 6, 'h020, 0);
        KRPT = 1'b1; step(); KRPT = 1'b0;
        chk_out("s_k2", 1, 6, 'h000, 1);
        RESUME = 1'b1; step(); RESUME = 1'b0;
        chk_out("s_r2", 1, 0, 'h000, 0);

        // higher-priority arrival in REQ, then asynchronous reset in SERVICE
        RUPT_REQ = 10'h080; step(); RUPT_REQ = '0;
        step();
        T12 = 1'b1; step(); T12 = 1'b0;
        chk_out("r_req", 0, 8, 'h080, 0);
        RUPT_REQ = 10'h040; step(); RUPT_REQ = '0;
        chk_out("r_hp", 0, 8, 'h0C0, 0);
        KRPT = 1'b1; RUPT_REQ = 10'h080; step(); KRPT = 1'b0; RUPT_REQ = '0;
        chk_out("r_svc", 1, 8, 'h0C0, 1);
        #2;
        SIM_RST = 1'b1;
        #1;
        chk_out("r_async", 1, 0, 'h000, 0);
        RUPT_REQ = '1; T12 = 1'b1; KRPT = 1'b1;
        step();
        chk_out("r_hold", 1, 0, 'h000, 0);
        #2;
        SIM_RST = 1'b0;
        clear_inputs();
        step();
        chk_out("r_after", 1, 0, 'h000, 0);
        RUPT_REQ = 10'h100; step(); RUPT_REQ = '0;
        step();
        T12 = 1'b1; step(); T12 = 1'b0;
        chk_out("r_again", 0, 9, 'h100, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
